// File: rtl/key_event_pkg.sv
// Shared definitions for the key_event button event generator:
// FSM state encoding, counter widths and the ms tick divisor.
package key_event_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    localparam int MS_CNT_W   = 16;
    localparam int TICK_CNT_W = 20;

    function automatic int tick_div(input int clk_fre);
        return clk_fre / 1000;
    endfunction

endpackage

// File: rtl/key_event_fsm.sv
// Per-button event FSM: turns one normalised level plus the shared ms tick
// into registered press/release/short/long/repeat pulses and a held level.
module key_event_fsm
    import key_event_pkg::*;
#(
    parameter int LONG_MS = 1000,
    parameter int REP_MS  = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic p,
    input  logic p_d,
    input  logic armed,
    input  logic tick,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    localparam logic [MS_CNT_W-1:0] LONG_LAST = MS_CNT_W'(LONG_MS - 1);
    localparam logic [MS_CNT_W-1:0] REP_LAST  = MS_CNT_W'(REP_MS - 1);

    state_t              state, state_nx;
    logic [MS_CNT_W-1:0] ms_cnt, ms_cnt_nx;
    logic                press_nx, release_nx, short_nx, long_nx, repeat_nx;
    logic                press_ev, release_ev;

    // armed blocks the fake press edge of a button that was held through reset
    assign press_ev   = p & ~p_d & armed;
    assign release_ev = ~p & p_d;

    always_comb begin
        state_nx   = state;
        ms_cnt_nx  = ms_cnt;
        press_nx   = 1'b0;
        release_nx = 1'b0;
        short_nx   = 1'b0;
        long_nx    = 1'b0;
        repeat_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (press_ev) begin
                    state_nx  = ST_HOLD;
                    ms_cnt_nx = '0;
                    press_nx  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (release_ev) begin
                    state_nx   = ST_IDLE;
                    release_nx = 1'b1;
                    short_nx   = 1'b1;
                end else if (tick) begin
                    if (ms_cnt == LONG_LAST) begin
                        state_nx  = ST_REPEAT;
                        ms_cnt_nx = '0;
                        long_nx   = 1'b1;
                    end else begin
                        ms_cnt_nx = ms_cnt + 16'd1;
                    end
                end
            end
            ST_REPEAT: begin
                if (release_ev) begin
                    state_nx   = ST_IDLE;
                    release_nx = 1'b1;
                end else if (tick) begin
                    if (ms_cnt == REP_LAST) begin
                        ms_cnt_nx = '0;
                        repeat_nx = 1'b1;
                    end else begin
                        ms_cnt_nx = ms_cnt + 16'd1;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            ms_cnt        <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            state         <= state_nx;
            ms_cnt        <= ms_cnt_nx;
            press_pulse   <= press_nx;
            release_pulse <= release_nx;
            short_pulse   <= short_nx;
            long_pulse    <= long_nx;
            repeat_pulse  <= repeat_nx;
        end
    end

    assign held = (state != ST_IDLE);

endmodule

// File: rtl/key_event.sv
// Button event generator top: normalises polarity, keeps the previous level,
// derives the shared 1 ms tick and runs one event FSM per button.
module key_event
    import key_event_pkg::*;
#(
    parameter int BT_WIDTH   = 8,
    parameter int CLK_FRE    = 50_000_000,
    parameter int ACTIVE_LOW = 1,
    parameter int LONG_MS    = 1000,
    parameter int REP_MS     = 200
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BT_WIDTH-1:0] btn_in,
    output logic [BT_WIDTH-1:0] press_pulse,
    output logic [BT_WIDTH-1:0] release_pulse,
    output logic [BT_WIDTH-1:0] short_pulse,
    output logic [BT_WIDTH-1:0] long_pulse,
    output logic [BT_WIDTH-1:0] repeat_pulse,
    output logic [BT_WIDTH-1:0] held
);

    localparam int                    TICK_DIV  = tick_div(CLK_FRE);
    localparam logic [TICK_CNT_W-1:0] TICK_LAST = TICK_CNT_W'(TICK_DIV - 1);
    localparam logic                  POL       = (ACTIVE_LOW != 0);

    logic [BT_WIDTH-1:0]   p, p_d, armed;
    logic [TICK_CNT_W-1:0] tick_cnt;
    logic                  tick;

    assign p = btn_in ^ {BT_WIDTH{POL}};

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 20'd1;
            tick     <= 1'b0;
        end
    end

    // A button only becomes armed once it has been seen released, so a
    // button held through reset cannot fire a press until re-pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_d   <= '0;
            armed <= ~p;
        end else begin
            p_d   <= p;
            armed <= armed | ~p;
        end
    end

    for (genvar i = 0; i < BT_WIDTH; i++) begin : g_btn
        key_event_fsm #(
            .LONG_MS (LONG_MS),
            .REP_MS  (REP_MS)
        ) u_fsm (
            .clk           (clk),
            .rst           (rst),
            .p             (p[i]),
            .p_d           (p_d[i]),
            .armed         (armed[i]),
            .tick          (tick),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .short_pulse   (short_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .repeat_pulse  (repeat_pulse[i]),
            .held          (held[i])
        );
    end

endmodule

// File: tb/tb_key_event.sv
// Scoreboard bench for key_event: button stimulus schedules expected pulses by
// edge index, and a negedge monitor pops and compares them every cycle.
module tb_key_event;

    localparam int BW      = 4;
    localparam int TICK    = 10;
    localparam int LONG_MS = 5;
    localparam int REP_MS  = 2;
    localparam int K_PRESS = 0, K_REL = 1, K_SHORT = 2, K_LONG = 3, K_REP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] btn_in = '1;
    logic [BW-1:0] press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held;

    typedef struct {
        int edge_idx;
        int kind;
        int btn;
    } ev_t;

    ev_t           sb[$];
    int            edge_n = 0;
    logic          last_rst = 1'b1;
    int            vectors = 0;
    int            miscompares = 0;
    int            held_from[BW];
    int            held_to[BW];
    int            long_edge[BW];
    logic [BW-1:0] armed_tb = '1;
    logic [BW-1:0] cur_btn = '1;

    key_event #(
        .BT_WIDTH   (BW),
        .CLK_FRE    (10_000),
        .ACTIVE_LOW (1),
        .LONG_MS    (LONG_MS),
        .REP_MS     (REP_MS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_in        (btn_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .short_pulse   (short_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held)
    );

    always #5 clk = ~clk;

    // Index of each non-reset edge since reset release; the tick is seen at edges 10, 20, ...
    always @(posedge clk) begin
        last_rst <= rst;
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s after edge %0d: got %0h, expected %0h", tag, edge_n - 1, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [BW-1:0] e [5];
        logic [BW-1:0] hexp;
        int            m;
        if (last_rst) begin
            checkOutput("reset_outputs",
                32'({press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held}), 32'd0);
        end else begin
            m = edge_n - 1;
            for (int k = 0; k < 5; k++) e[k] = '0;
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].edge_idx == m) begin
                    e[sb[k].kind][sb[k].btn] = 1'b1;
                    sb.delete(k);
                end
            end
            for (int i = 0; i < BW; i++)
                hexp[i] = (held_from[i] >= 0) && (m >= held_from[i]) && ((held_to[i] < 0) || (m < held_to[i]));
            checkOutput("press_pulse",   32'(press_pulse),   32'(e[K_PRESS]));
            checkOutput("release_pulse", 32'(release_pulse), 32'(e[K_REL]));
            checkOutput("short_pulse",   32'(short_pulse),   32'(e[K_SHORT]));
            checkOutput("long_pulse",    32'(long_pulse),    32'(e[K_LONG]));
            checkOutput("repeat_pulse",  32'(repeat_pulse),  32'(e[K_REP]));
            checkOutput("held",          32'(held),          32'(hexp));
        end
    end

    // Drive a new button vector at a negedge and schedule the pulses it implies
    task automatic applyStimulus(input logic [BW-1:0] nb, input int cycles);
        int n;
        int lt;
        n = edge_n;
        for (int i = 0; i < BW; i++) begin
            if (!nb[i] && cur_btn[i]) begin
                if (armed_tb[i]) begin
                    held_from[i] = n;
                    held_to[i]   = -1;
                    lt           = (n / TICK + LONG_MS) * TICK;
                    long_edge[i] = lt;
                    sb.push_back('{n, K_PRESS, i});
                    sb.push_back('{lt, K_LONG, i});
                    for (int k = 1; k <= 20; k++)
                        sb.push_back('{lt + k * REP_MS * TICK, K_REP, i});
                end
            end else if (nb[i] && !cur_btn[i]) begin
                armed_tb[i] = 1'b1;
                if (held_from[i] >= 0 && held_to[i] < 0) begin
                    held_to[i] = n;
                    for (int k = sb.size() - 1; k >= 0; k--)
                        if (sb[k].btn == i && (sb[k].kind == K_LONG || sb[k].kind == K_REP) && sb[k].edge_idx >= n)
                            sb.delete(k);
                    sb.push_back('{n, K_REL, i});
                    if (n <= long_edge[i]) sb.push_back('{n, K_SHORT, i});
                end
            end
        end
        cur_btn = nb;
        btn_in  = nb;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic doReset(input int cycles);
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        for (int i = 0; i < BW; i++) begin
            held_from[i] = -1;
            held_to[i]   = -1;
            long_edge[i] = 0;
        end
        armed_tb = cur_btn;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitUntilEdge(input int target);
        int budget;
        budget = 0;
        while (edge_n < target && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("wait_budget", 32'(budget < 1000), 32'd1);
    endtask

    initial begin
        int np;
        @(negedge clk);
        doReset(3);

        // idle after reset with buttons released
        applyStimulus(4'b1111, 30);

        // press, then reset while still held: no press until released and re-pressed
        applyStimulus(4'b1110, 15);
        doReset(2);
        applyStimulus(4'b1110, 100);
        applyStimulus(4'b1111, 5);
        applyStimulus(4'b1110, 10);
        applyStimulus(4'b1111, 10);

        // short press
        applyStimulus(4'b1110, 20);
        applyStimulus(4'b1111, 10);

        // long press with auto-repeat
        applyStimulus(4'b1101, 120);
        applyStimulus(4'b1111, 10);

        // release sampled on the very tick that would fire long_pulse
        np = edge_n;
        applyStimulus(4'b1011, 1);
        waitUntilEdge((np / TICK + LONG_MS) * TICK);
        applyStimulus(4'b1111, 10);

        // two buttons pressed together, released at different times
        applyStimulus(4'b0011, 30);
        applyStimulus(4'b0111, 60);
        applyStimulus(4'b1111, 10);

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
